// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding the decoder.
// Owns the program counter, issues word requests to instruction memory over a
// req/ack handshake and registers {PC+4, instruction} into IF_ID. Handles
// downstream stall and branch redirect from EX.
// Optional feature macro: FETCH_SKID_EN (one-entry skid buffer that captures
// an instruction acked while stalled; without it the instruction is refetched).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [63:0] IF_ID,
  output logic        if_valid
);

  localparam logic [63:0] BUBBLE = {32'h0000_0000, NOP_INSTR};

`ifdef FETCH_SKID_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_HOLD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;
`endif

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] req_addr, req_addr_nx;
  logic [63:0] if_id_nx;
  logic        if_valid_nx;
  logic [31:0] seq_pc;
  logic [31:0] redir_pc;
  logic        pending;
  logic        unused_redir_lo;

`ifdef FETCH_SKID_EN
  logic [63:0] skid_data, skid_data_nx;
`else
  // Set when an ack was thrown away under stall: the request is complete, so
  // imem_req drops until stall falls and the same address is asked for again.
  logic        refetch, refetch_nx;
`endif

  assign seq_pc          = req_addr + 32'd4;
  assign redir_pc        = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lo = ^redirect_pc[1:0];
  assign imem_addr       = req_addr;
  assign pending         = imem_req && !imem_ack;

`ifdef FETCH_SKID_EN
  assign imem_req = (state == S_REQ) || (state == S_DROP);
`else
  assign imem_req = ((state == S_REQ) && !refetch) || (state == S_DROP);
`endif

  // Next-state, PC and IF_ID computation; redirect outranks everything else.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    req_addr_nx = req_addr;
    if_id_nx    = IF_ID;
    if_valid_nx = if_valid;
`ifdef FETCH_SKID_EN
    skid_data_nx = skid_data;
`else
    refetch_nx   = refetch;
`endif

    if (redirect_valid) begin
      if_id_nx    = BUBBLE;
      if_valid_nx = 1'b0;
      pc_nx       = redir_pc;
`ifdef FETCH_SKID_EN
      skid_data_nx = BUBBLE;
`else
      refetch_nx   = 1'b0;
`endif
      if (pending) begin
        state_nx = S_DROP;
      end else begin
        state_nx    = S_REQ;
        req_addr_nx = redir_pc;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state_nx    = S_REQ;
          req_addr_nx = pc;
          if (!stall) begin
            if_id_nx    = BUBBLE;
            if_valid_nx = 1'b0;
          end
        end

        S_REQ: begin
`ifndef FETCH_SKID_EN
          if (refetch) begin
            if (!stall) begin
              refetch_nx  = 1'b0;
              if_id_nx    = BUBBLE;
              if_valid_nx = 1'b0;
            end
          end else
`endif
          if (imem_ack) begin
            if (!stall) begin
              if_id_nx    = {seq_pc, imem_rdata};
              if_valid_nx = 1'b1;
              pc_nx       = seq_pc;
              req_addr_nx = seq_pc;
            end else begin
`ifdef FETCH_SKID_EN
              skid_data_nx = {seq_pc, imem_rdata};
              pc_nx        = seq_pc;
              req_addr_nx  = seq_pc;
              state_nx     = S_HOLD;
`else
              refetch_nx   = 1'b1;
`endif
            end
          end else if (!stall) begin
            if_id_nx    = BUBBLE;
            if_valid_nx = 1'b0;
          end
        end

        S_DROP: begin
          if (imem_ack) begin
            state_nx    = S_REQ;
            req_addr_nx = pc;
          end
          if (!stall) begin
            if_id_nx    = BUBBLE;
            if_valid_nx = 1'b0;
          end
        end

`ifdef FETCH_SKID_EN
        S_HOLD: begin
          if (!stall) begin
            if_id_nx    = skid_data;
            if_valid_nx = 1'b1;
            state_nx    = S_REQ;
            req_addr_nx = pc;
          end
        end
`endif

        default: state_nx = S_IDLE;
      endcase
    end
  end

  // State, PC and pipeline register update with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      IF_ID    <= BUBBLE;
      if_valid <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_data <= BUBBLE;
`else
      refetch   <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      req_addr <= req_addr_nx;
      IF_ID    <= if_id_nx;
      if_valid <= if_valid_nx;
`ifdef FETCH_SKID_EN
      skid_data <= skid_data_nx;
`else
      refetch   <= refetch_nx;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// A small memory model acks `lat` cycles after a request is first seen
// (lat = 0 gives a same-cycle ack) and returns addr ^ 32'hDEAD_0000.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [63:0] IF_ID;
  logic        if_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned lat      = 0;
  int unsigned wait_cnt = 0;

  localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;

  fetch_stage #(
    .RESET_PC (32'h0000_0100),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .IF_ID         (IF_ID),
    .if_valid      (if_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = instr_of(imem_addr);

  always @(posedge clock) begin
    if (reset || !imem_req || imem_ack) wait_cnt <= 0;
    else                                wait_cnt <= wait_cnt + 1;
  end

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lat = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lat = 0;
    repeat (2) @(negedge clock);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_checks++; if (IF_ID !== BUB) begin n_fail++; $display("FAIL rst_ifid: got %h want %h", IF_ID, BUB); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rst_first_addr: got %h want 00000100", imem_addr); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] ea [3] = '{32'h104, 32'h108, 32'h10C};
    logic [63:0] ei [3] = '{64'h0000_0104_DEAD_0100, 64'h0000_0108_DEAD_0104, 64'h0000_010C_DEAD_0108};
    do_reset();
    @(negedge clock);
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL zw_valid0: got %b want 0", if_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++; if (imem_addr !== ea[i]) begin n_fail++; $display("FAIL zw_addr%0d: got %h want %h", i, imem_addr, ea[i]); end
      n_checks++; if (IF_ID !== ei[i]) begin n_fail++; $display("FAIL zw_ifid%0d: got %h want %h", i, IF_ID, ei[i]); end
      n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid%0d: got %b want 1", i, if_valid); end
    end
  endtask

  task automatic test_wait_state();
    logic        ev [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] ei [4] = '{64'h0000_0104_DEAD_0100, BUB, 64'h0000_0108_DEAD_0104, BUB};
    do_reset();
    lat = 1;
    repeat (2) @(negedge clock);
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL ws_first_bubble: got %b want 0", if_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_checks++; if (if_valid !== ev[i]) begin n_fail++; $display("FAIL ws_valid%0d: got %b want %b", i, if_valid, ev[i]); end
      n_checks++; if (IF_ID !== ei[i]) begin n_fail++; $display("FAIL ws_ifid%0d: got %h want %h", i, IF_ID, ei[i]); end
    end
  endtask

  task automatic test_stall();
    logic [63:0] got [2] = '{64'h0, 64'h0};
    int k = 0;
    do_reset();
    lat = 1;
    repeat (3) @(negedge clock);
    n_checks++; if (IF_ID !== 64'h0000_0104_DEAD_0100) begin n_fail++; $display("FAIL st_pre: got %h want 00000104dead0100", IF_ID); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++; if (IF_ID !== 64'h0000_0104_DEAD_0100) begin n_fail++; $display("FAIL st_frozen%0d: got %h want 00000104dead0100", i, IF_ID); end
      n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid%0d: got %b want 1", i, if_valid); end
      if (i > 0) begin
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_req_low%0d: got %b want 0", i, imem_req); end
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 12 && k < 2; i++) begin
      @(negedge clock);
      if (if_valid === 1'b1) begin got[k] = IF_ID; k++; end
    end
    n_checks++; if (k != 2) begin n_fail++; $display("FAIL st_timeout: got %0d valid instrs want 2", k); end
    n_checks++; if (got[0] !== 64'h0000_0108_DEAD_0104) begin n_fail++; $display("FAIL st_after0: got %h want 00000108dead0104", got[0]); end
    n_checks++; if (got[1] !== 64'h0000_010C_DEAD_0108) begin n_fail++; $display("FAIL st_after1: got %h want 0000010cdead0108", got[1]); end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    lat = 3;
    @(negedge clock);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      redirect_valid = 1'b0;
      n_checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rp_hold%0d: got req %b addr %h want 1 00000100", i, imem_req, imem_addr); end
      n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rp_valid%0d: got %b want 0", i, if_valid); end
    end
    @(negedge clock);
    n_checks++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rp_new_addr: got req %b addr %h want 1 00000200", imem_req, imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rp_no_stale: got %b want 0", if_valid); end
    lat = 0;
    @(negedge clock);
    n_checks++; if (IF_ID !== 64'h0000_0204_DEAD_0200 || if_valid !== 1'b1) begin n_fail++; $display("FAIL rp_first: got %h v%b want 00000204dead0200 v1", IF_ID, if_valid); end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    repeat (2) @(negedge clock);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clock);
    stall = 1'b0; redirect_valid = 1'b0;
    n_checks++; if (IF_ID !== BUB) begin n_fail++; $display("FAIL rs_ifid: got %h want %h", IF_ID, BUB); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rs_valid: got %b want 0", if_valid); end
    n_checks++; if (imem_addr !== 32'h300) begin n_fail++; $display("FAIL rs_addr: got %h want 00000300", imem_addr); end
    @(negedge clock);
    n_checks++; if (IF_ID !== 64'h0000_0304_DEAD_0300 || if_valid !== 1'b1) begin n_fail++; $display("FAIL rs_next: got %h v%b want 00000304dead0300 v1", IF_ID, if_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clock);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clock);
    redirect_valid = 1'b0;
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_addr: got %h want fffffffc", imem_addr); end
    @(negedge clock);
    n_checks++; if (IF_ID !== 64'h0000_0000_2152_FFFC || if_valid !== 1'b1) begin n_fail++; $display("FAIL wr_ifid: got %h v%b want 000000002152fffc v1", IF_ID, if_valid); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_next_addr: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (2) @(negedge clock);
    lat = 4; stall = 1'b1;
    @(negedge clock);
    n_checks++; if (if_valid !== 1'b1 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got v%b req %b want v1 req1", if_valid, imem_req); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; stall = 1'b0; lat = 0;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %b want 0", imem_req); end
    n_checks++; if (IF_ID !== BUB || if_valid !== 1'b0) begin n_fail++; $display("FAIL rm_ifid: got %h v%b want %h v0", IF_ID, if_valid, BUB); end
    @(negedge clock);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rm_restart: got req %b addr %h want 1 00000100", imem_req, imem_addr); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_state();
    test_stall();
    test_redirect_pending();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
